// File: rtl/thread_fetch_unit.sv
// Fetch stage for the two-thread interleaved core: per-thread PCs, round-robin imem address, IF/ID register.
// Optional FETCH_SPIN_PARK_EN parks a thread that reaches its own "BNZ to self with b==0" done-spin.

`ifdef FETCH_SPIN_PARK_EN
`ifndef OP_BNZ
`define OP_BNZ 4'hA
`endif
`endif

module tfu_thread_pc #(
  parameter logic [7:0] START = 8'd0,
  parameter logic [7:0] STEP  = 8'd2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       adv,
  input  logic       ld,
  input  logic [7:0] tgt,
  output logic [7:0] pc
);
  // A redirect load wins over the sequential advance; targets are halfword aligned.
  always_ff @(posedge clk) begin
    if (!rst_n)   pc <= START;
    else if (ld)  pc <= {tgt[7:1], 1'b0};
    else if (adv) pc <= pc + STEP;
  end
endmodule

module thread_fetch_unit #(
  parameter logic [7:0] T0_START = 8'd0,
  parameter logic [7:0] T1_START = 8'd100,
  parameter logic [7:0] PC_STEP  = 8'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [7:0]  imem_pc,
  input  logic [15:0] imem_instr,
  input  logic        id_stall,
  input  logic        redir_valid,
  input  logic        redir_tid,
  input  logic [7:0]  redir_target,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [7:0]  if_pc,
  output logic        if_tid,
  output logic [1:0]  thread_parked
);
  logic [1:0][7:0] pc;
  logic [1:0]      adv, ld;
  logic            cur_tid, nxt_tid, tid_upd;
  logic            fetch_en, redir_cur;
  logic [1:0]      parked;

  assign imem_pc   = pc[cur_tid];
  assign redir_cur = redir_valid && (redir_tid == cur_tid);
  assign fetch_en  = !id_stall && !parked[cur_tid];
  assign adv       = fetch_en ? (cur_tid ? 2'b10 : 2'b01) : 2'b00;
  assign ld        = redir_valid ? (redir_tid ? 2'b10 : 2'b01) : 2'b00;

  for (genvar t = 0; t < 2; t++) begin : g_thr
    tfu_thread_pc #(.START((t == 0) ? T0_START : T1_START), .STEP(PC_STEP)) u_pc (
      .clk   (clk),
      .rst_n (rst_n),
      .adv   (adv[t]),
      .ld    (ld[t]),
      .tgt   (redir_target),
      .pc    (pc[t])
    );
  end

`ifdef FETCH_SPIN_PARK_EN
  logic       spin;
  logic [1:0] parked_n;

  assign spin = (imem_instr[15:12] == `OP_BNZ) && (imem_instr[7:4] == 4'd0) &&
                ({imem_instr[11:8], imem_instr[3:0]} == imem_pc);

  always_comb begin
    parked_n = parked;
    if (fetch_en && !redir_cur && spin) parked_n[cur_tid] = 1'b1;
    if (redir_valid) parked_n[redir_tid] = 1'b0;
    // Prefer the other thread; stay put only when it is parked.
    nxt_tid = parked_n[~cur_tid] ? cur_tid : ~cur_tid;
    // A parked current thread may move on even under stall so it never blocks the live one.
    tid_upd = !id_stall || parked[cur_tid];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) parked <= 2'b00;
    else        parked <= parked_n;
  end
`else
  assign parked  = 2'b00;
  assign nxt_tid = ~cur_tid;
  assign tid_upd = !id_stall;
`endif

  assign thread_parked = parked;

  always_ff @(posedge clk) begin
    if (!rst_n)       cur_tid <= 1'b0;
    else if (tid_upd) cur_tid <= nxt_tid;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_valid <= 1'b0;
      if_instr <= 16'd0;
      if_pc    <= 8'd0;
      if_tid   <= 1'b0;
    end else if (fetch_en) begin
      if_instr <= imem_instr;
      if_pc    <= imem_pc;
      if_tid   <= cur_tid;
      if_valid <= !redir_cur;
    end else if (!id_stall) begin
      if_valid <= 1'b0;
    end else if (redir_valid && if_valid && (if_tid == redir_tid)) begin
      if_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_thread_fetch_unit.sv
// Bench for thread_fetch_unit: directed vector table, randomized run against a queue-free reference model,
// PC wrap on a second instance, and the spin-park sequence when FETCH_SPIN_PARK_EN is defined.

`ifdef FETCH_SPIN_PARK_EN
`ifndef OP_BNZ
`define OP_BNZ 4'hA
`endif
`endif

module tb_thread_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  imem_pc, w_pc;
  logic [15:0] imem_instr, w_instr;
  logic        id_stall, redir_valid, redir_tid;
  logic [7:0]  redir_target;
  logic        if_valid, if_tid, w_valid, w_tid;
  logic [15:0] if_instr, w_if_instr;
  logic [7:0]  if_pc, w_if_pc;
  logic [1:0]  thread_parked, w_parked;
  logic        spin_on;
  logic [15:0] spin_word;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Ordinary code never matches the spin idiom: the b field is always 1.
  function automatic logic [15:0] imem_f(input logic [7:0] a);
    return {a, 4'h1, a[3:0] ^ 4'h5};
  endfunction

  always_comb imem_instr = (spin_on && imem_pc == 8'd12) ? spin_word : imem_f(imem_pc);
  assign w_instr = imem_f(w_pc);

  thread_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_pc(imem_pc), .imem_instr(imem_instr),
    .id_stall(id_stall), .redir_valid(redir_valid), .redir_tid(redir_tid),
    .redir_target(redir_target), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .if_tid(if_tid), .thread_parked(thread_parked)
  );

  thread_fetch_unit #(.T0_START(8'd254)) u_wrap (
    .clk(clk), .rst_n(rst_n), .imem_pc(w_pc), .imem_instr(w_instr),
    .id_stall(1'b0), .redir_valid(1'b0), .redir_tid(1'b0),
    .redir_target(8'd0), .if_valid(w_valid), .if_instr(w_if_instr),
    .if_pc(w_if_pc), .if_tid(w_tid), .thread_parked(w_parked)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit         st;
    bit         rv;
    bit         rt;
    logic [7:0] tg;
    logic [7:0] e_im;
    bit         e_v;
    logic [7:0] e_pc;
    bit         e_tid;
  } vec_t;

  function automatic vec_t mk(bit st, bit rv, bit rt, logic [7:0] tg,
                              logic [7:0] e_im, bit e_v, logic [7:0] e_pc, bit e_tid);
    vec_t v;
    v.st = st; v.rv = rv; v.rt = rt; v.tg = tg;
    v.e_im = e_im; v.e_v = e_v; v.e_pc = e_pc; v.e_tid = e_tid;
    return v;
  endfunction

  // Reference model: the architectural state named by the block's behaviour.
  logic [7:0]  m_pc[2];
  bit          m_cur;
  bit          m_v;
  logic [7:0]  m_ipc;
  bit          m_itid;
  logic [15:0] m_iin;

  task automatic m_reset();
    m_pc[0] = 8'd0; m_pc[1] = 8'd100; m_cur = 0;
    m_v = 0; m_ipc = 8'd0; m_itid = 0; m_iin = 16'd0;
  endtask

  task automatic m_step(input bit st, input bit rv, input bit rt, input logic [7:0] tg);
    if (!st) begin
      m_v = !(rv && rt == m_cur);
      m_ipc = m_pc[m_cur]; m_itid = m_cur; m_iin = imem_f(m_pc[m_cur]);
      m_pc[m_cur] = 8'((int'(m_pc[m_cur]) + 2) % 256);
      m_cur = !m_cur;
    end else if (rv && m_v && m_itid == rt) begin
      m_v = 0;
    end
    if (rv) m_pc[rt] = tg & 8'hFE;
  endtask

  vec_t tv[18];
  logic [7:0] wexp[4];

  initial begin
    rst_n = 1'b0; id_stall = 0; redir_valid = 0; redir_tid = 0; redir_target = 0;
    spin_on = 0; spin_word = 16'd0;

    tv[0]  = mk(0,0,0,8'h00, 8'd0,   1, 8'd0,   0);
    tv[1]  = mk(0,0,0,8'h00, 8'd100, 1, 8'd100, 1);
    tv[2]  = mk(0,0,0,8'h00, 8'd2,   1, 8'd2,   0);
    tv[3]  = mk(0,0,0,8'h00, 8'd102, 1, 8'd102, 1);
    tv[4]  = mk(1,0,0,8'h00, 8'd4,   1, 8'd102, 1);
    tv[5]  = mk(1,0,0,8'h00, 8'd4,   1, 8'd102, 1);
    tv[6]  = mk(1,0,0,8'h00, 8'd4,   1, 8'd102, 1);
    tv[7]  = mk(0,0,0,8'h00, 8'd4,   1, 8'd4,   0);
    tv[8]  = mk(1,1,0,8'd6,  8'd104, 0, 8'd4,   0);
    tv[9]  = mk(0,0,0,8'h00, 8'd104, 1, 8'd104, 1);
    tv[10] = mk(0,0,0,8'h00, 8'd6,   1, 8'd6,   0);
    tv[11] = mk(0,1,1,8'h6F, 8'd106, 0, 8'd106, 1);
    tv[12] = mk(0,0,0,8'h00, 8'd8,   1, 8'd8,   0);
    tv[13] = mk(0,0,0,8'h00, 8'h6E,  1, 8'h6E,  1);
    tv[14] = mk(0,1,1,8'h80, 8'd10,  1, 8'd10,  0);
    tv[15] = mk(0,0,0,8'h00, 8'h80,  1, 8'h80,  1);
    tv[16] = mk(1,1,0,8'h21, 8'd12,  1, 8'h80,  1);
    tv[17] = mk(0,0,0,8'h00, 8'h20,  1, 8'h20,  0);
    wexp[0] = 8'd254; wexp[1] = 8'd100; wexp[2] = 8'd0; wexp[3] = 8'd102;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_pc", 32'(if_pc), 32'd0);
    chk("rst_tid", 32'(if_tid), 32'd0);
    chk("rst_instr", 32'(if_instr), 32'd0);
    chk("rst_imem_pc", 32'(imem_pc), 32'd0);
    chk("rst_parked", 32'(thread_parked), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      id_stall = tv[i].st; redir_valid = tv[i].rv; redir_tid = tv[i].rt; redir_target = tv[i].tg;
      #1;
      chk($sformatf("vec%0d_imem_pc", i), 32'(imem_pc), 32'(tv[i].e_im));
      if (i < 4) chk($sformatf("wrap%0d_imem_pc", i), 32'(w_pc), 32'(wexp[i]));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i), 32'(if_valid), 32'(tv[i].e_v));
      if (tv[i].e_v) begin
        chk($sformatf("vec%0d_pc", i), 32'(if_pc), 32'(tv[i].e_pc));
        chk($sformatf("vec%0d_tid", i), 32'(if_tid), 32'(tv[i].e_tid));
        chk($sformatf("vec%0d_instr", i), 32'(if_instr), 32'(imem_f(tv[i].e_pc)));
      end
    end

    // Randomized run, with one mid-stream reset.
    id_stall = 0; redir_valid = 0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_reset();
    for (int c = 0; c < 400; c++) begin
      bit do_rst;
      do_rst = (c == 200);
      id_stall = ($urandom_range(3) == 0);
      redir_valid = ($urandom_range(4) == 0);
      redir_tid = 1'($urandom_range(1));
      redir_target = 8'($urandom);
      rst_n = !do_rst;
      #1;
      chk("rnd_imem_pc", 32'(imem_pc), 32'(m_pc[m_cur]));
      if (do_rst) m_reset();
      else m_step(id_stall, redir_valid, redir_tid, redir_target);
      @(posedge clk);
      #1;
      chk("rnd_valid", 32'(if_valid), 32'(m_v));
      if (m_v) begin
        chk("rnd_pc", 32'(if_pc), 32'(m_ipc));
        chk("rnd_tid", 32'(if_tid), 32'(m_itid));
        chk("rnd_instr", 32'(if_instr), 32'(m_iin));
      end
      if (thread_parked !== 2'b00) chk("rnd_parked", 32'(thread_parked), 32'd0);
    end
    rst_n = 1'b1;

`ifdef FETCH_SPIN_PARK_EN
    // Thread 0 reaches a BNZ-to-self at 12 and parks; thread 1 then owns every fetch slot.
    id_stall = 0; redir_valid = 0;
    spin_word = {`OP_BNZ, 4'h0, 4'h0, 4'hC};
    spin_on = 1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (13) @(posedge clk);
    #1;
    chk("park_flag", 32'(thread_parked), 32'd1);
    chk("park_if_pc", 32'(if_pc), 32'd12);
    chk("park_if_valid", 32'(if_valid), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("park_imem%0d", k), 32'(imem_pc), 32'(112 + 2 * k));
      @(posedge clk); #1;
      chk($sformatf("park_tid%0d", k), 32'(if_tid), 32'd1);
    end
    redir_valid = 1; redir_tid = 0; redir_target = 8'h40;
    @(posedge clk); #1;
    redir_valid = 0;
    chk("unpark_flag", 32'(thread_parked), 32'd0);
    chk("unpark_imem", 32'(imem_pc), 32'h40);
    spin_on = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/thread_fetch_unit.md
Name: thread_fetch_unit

Overview:
- Instruction-fetch stage of the fine-grained interleaved two-thread processor.
- Keeps one PC per thread and drives the combinational imem address each cycle, switching thread every cycle (round-robin).
- Registers the returned 16-bit instruction, with its PC and thread id, into the IF/ID pipeline register.
- Accepts branch redirects from execute and squashes wrong-path fetches.

Parameters:
- T0_START, 8'd0, thread 0 reset PC
- T1_START, 8'd100, thread 1 reset PC
- PC_STEP, 8'd2, PC increment per fetched instruction

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  synchronous active-low reset
- imem_pc  output  8  fetch address to imem (combinational from current thread PC)
- imem_instr  input  16  instruction returned combinationally by imem
- id_stall  input  1  decode cannot accept; hold IF/ID register and all PCs
- redir_valid  input  1  branch taken in execute
- redir_tid  input  1  thread owning the redirect
- redir_target  input  8  new PC for redir_tid
- if_valid  output  1  IF/ID register holds a live instruction
- if_instr  output  16  fetched instruction {op[15:12], a[11:8], b[7:4], c[3:0]}
- if_pc  output  8  PC of if_instr
- if_tid  output  1  thread of if_instr
- thread_parked  output  2  per-thread parked flag (see Optional Feature)

Behaviour:
- All state updates at posedge clk. When rst_n=0: pc0=T0_START, pc1=T1_START, cur_tid=0, if_valid=0, if_instr=0, if_pc=0, if_tid=0, thread_parked=0.
- imem_pc = pc[cur_tid] at all times. One-cycle latency: the address presented in cycle N appears on if_* after edge N+1.
- Normal cycle (no stall, no redirect):
  - if_instr<=imem_instr, if_pc<=pc[cur_tid], if_tid<=cur_tid, if_valid<=1.
  - pc[cur_tid]<=pc[cur_tid]+PC_STEP, modulo 256 (8'd254 wraps to 8'd0).
  - cur_tid toggles.
- id_stall=1: if_* hold, all PCs hold, cur_tid holds. Redirect is still processed (see below).
- redir_valid=1:
  - pc[redir_tid]<=redir_target with bit0 forced to 0.
  - This update overrides any increment of that PC in the same cycle.
  - If cur_tid==redir_tid, the fetch this cycle is wrong-path: if_valid<=0 (unless stalled) and cur_tid still toggles.
  - If if_valid=1 and if_tid==redir_tid, the held IF/ID entry is squashed (if_valid<=0) even when id_stall=1.
- Redirect for the other thread: no effect on this cycle's fetch.
- Reset has priority over stall and redirect. Reset mid-stream discards the IF/ID entry and returns both PCs to their start values.
- No instruction decode in this block except the BNZ check under the Optional Feature.

Optional Feature:
- Macro: FETCH_SPIN_PARK_EN.
- Defined:
  - A fetched instruction with op==`OP_BNZ, b==4'd0 and {a,c}==its own PC (the done-spin idiom) sets thread_parked[tid] when it is latched.
  - A parked thread is skipped by round-robin; the other thread fetches every cycle.
  - If both threads are parked: if_valid<=0 and imem_pc holds.
  - A redirect to a parked thread clears its parked flag. Reset clears both flags.
- Undefined: thread_parked is tied to 0 and strict alternation is kept.

Test Plan:
- Reset release, no stall: imem_pc sequence 0,100,2,102,4,104; if_* follows one cycle later with if_tid alternating 0,1.
- id_stall=1 for 3 cycles after if_pc=102 latched: if_* frozen at pc 102/tid 1, imem_pc frozen at 4; on release fetch resumes at 4.
- Redirect tid0 target 6 while if_tid=0 is held and cur_tid=1: IF/ID squashed (if_valid=0 next cycle), next thread-0 fetch address is 6.
- Redirect tid1 target 8'h6F in the cycle cur_tid=1: that fetch is dropped and pc1 becomes 0x6E.
- PC wrap: T0_START=254, no redirects: thread 0 addresses 254 then 0.
- With FETCH_SPIN_PARK_EN, instruction at address 12 = BNZ a0,b0,c12: after it is latched, thread_parked=2'b01 and imem_pc shows only thread-1 addresses every cycle.
